// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard detection for the 5-stage MIPS core.
// Covers load-use, branch-in-ID operand dependencies and the multi-cycle
// mult/div unit, and keeps a saturating count of stalled cycles.
module hazard_ctrl #(
  parameter int unsigned MD_CYCLES = 32,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_usesRs,
  input  logic             id_usesRt,
  input  logic             id_branch,
  input  logic             id_branchTaken,
  input  logic             id_mdUse,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regWrite,
  input  logic             ex_memRead,
  input  logic             ex_mdStart,
  input  logic [4:0]       mem_rd,
  input  logic             mem_memRead,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             md_busy,
  output logic             md_overrun,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned     MD_W    = $clog2(MD_CYCLES);
  localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MD_CYCLES - 1);
  localparam logic [MD_W-1:0] MD_ONE  = MD_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_t;

  md_state_t        r_state;
  logic [MD_W-1:0]  r_md_cnt;
  logic             r_md_overrun;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_ex_match;
  logic w_mem_match;
  logic w_md_busy;
  logic w_md_last;
  logic w_lu;
  logic w_bex;
  logic w_bmm;
  logic w_mdh;
  logic w_stall;

  // Register r is a live source operand of the ID instruction; r0 never is.
  function automatic logic f_match(
    input logic [4:0] r,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       use_rs,
    input logic       use_rt
  );
    return (r != 5'd0) && (((r == rs) && use_rs) || ((r == rt) && use_rt));
  endfunction

  // Operand dependency on the EX and MEM destinations.
  always_comb begin
    w_ex_match  = f_match(ex_rd,  id_rs, id_rt, id_usesRs, id_usesRt);
    w_mem_match = f_match(mem_rd, id_rs, id_rt, id_usesRs, id_usesRt);
  end

  // The HI/LO result lands at the edge closing the md_last cycle, so a
  // reader sitting in ID during that cycle is released and gets it forwarded.
  always_comb begin
    w_md_busy = (r_state == S_BUSY);
    w_md_last = w_md_busy && (r_md_cnt == MD_ONE);
  end

  // Stall terms; a branch on a load in EX stalls twice (bex, then bmm).
  always_comb begin
    w_lu    = ex_memRead  && ex_regWrite && w_ex_match;
    w_bex   = id_branch   && ex_regWrite && w_ex_match;
    w_bmm   = id_branch   && mem_memRead && w_mem_match;
    w_mdh   = id_mdUse    && w_md_busy   && !w_md_last;
    w_stall = w_lu || w_bex || w_bmm || w_mdh;
  end

  // Pipeline control; a stall suppresses the flush until operands resolve.
  always_comb begin
    pc_write    = !w_stall;
    ifid_write  = !w_stall;
    idex_bubble = w_stall;
    ifid_flush  = id_branchTaken && !w_stall;
  end

  // Mult/div occupancy FSM: a start in BUSY is dropped and flagged sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_md_cnt     <= '0;
      r_md_overrun <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (ex_mdStart) begin
        r_state  <= S_BUSY;
        r_md_cnt <= MD_LOAD;
      end
    end else begin
      if (ex_mdStart) begin
        r_md_overrun <= 1'b1;
      end
      if (r_md_cnt <= MD_ONE) begin
        r_state  <= S_IDLE;
        r_md_cnt <= '0;
      end else begin
        r_md_cnt <= r_md_cnt - MD_ONE;
      end
    end
  end

  // Stalled-cycle performance counter, sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

  assign md_busy    = w_md_busy;
  assign md_overrun = r_md_overrun;
  assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors for hazard_ctrl, two instances sharing
// inputs (wide counter and 2-bit saturating counter, both MD_CYCLES=4).
module tb_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_usesRs;
  logic       id_usesRt;
  logic       id_branch;
  logic       id_branchTaken;
  logic       id_mdUse;
  logic [4:0] ex_rd;
  logic       ex_regWrite;
  logic       ex_memRead;
  logic       ex_mdStart;
  logic [4:0] mem_rd;
  logic       mem_memRead;

  logic        a_pc_write, a_ifid_write, a_idex_bubble, a_ifid_flush;
  logic        a_md_busy, a_md_overrun;
  logic [15:0] a_stall_cnt;
  logic        b_pc_write, b_ifid_write, b_idex_bubble, b_ifid_flush;
  logic        b_md_busy, b_md_overrun;
  logic [1:0]  b_stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_ctrl #(.MD_CYCLES(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_usesRs(id_usesRs), .id_usesRt(id_usesRt),
    .id_branch(id_branch), .id_branchTaken(id_branchTaken), .id_mdUse(id_mdUse),
    .ex_rd(ex_rd), .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
    .ex_mdStart(ex_mdStart), .mem_rd(mem_rd), .mem_memRead(mem_memRead),
    .pc_write(a_pc_write), .ifid_write(a_ifid_write), .idex_bubble(a_idex_bubble),
    .ifid_flush(a_ifid_flush), .md_busy(a_md_busy), .md_overrun(a_md_overrun),
    .stall_cnt(a_stall_cnt)
  );

  hazard_ctrl #(.MD_CYCLES(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_usesRs(id_usesRs), .id_usesRt(id_usesRt),
    .id_branch(id_branch), .id_branchTaken(id_branchTaken), .id_mdUse(id_mdUse),
    .ex_rd(ex_rd), .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
    .ex_mdStart(ex_mdStart), .mem_rd(mem_rd), .mem_memRead(mem_memRead),
    .pc_write(b_pc_write), .ifid_write(b_ifid_write), .idex_bubble(b_idex_bubble),
    .ifid_flush(b_ifid_flush), .md_busy(b_md_busy), .md_overrun(b_md_overrun),
    .stall_cnt(b_stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clr_in();
    id_rs = 5'd0; id_rt = 5'd0; id_usesRs = 1'b0; id_usesRt = 1'b0;
    id_branch = 1'b0; id_branchTaken = 1'b0; id_mdUse = 1'b0;
    ex_rd = 5'd0; ex_regWrite = 1'b0; ex_memRead = 1'b0; ex_mdStart = 1'b0;
    mem_rd = 5'd0; mem_memRead = 1'b0;
  endtask

  // One cycle later, 1 time unit past the rising edge.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr_in();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    next_cyc();
  endtask

  // Load-use on rs, ID reading rs=5 with EX load rd=5.
  task automatic set_lu();
    clr_in();
    ex_memRead = 1'b1; ex_regWrite = 1'b1; ex_rd = 5'd5;
    id_rs = 5'd5; id_usesRs = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr_in();
    #3;
    chk("rst_pc_write",   32'(a_pc_write),   32'd1);
    chk("rst_ifid_write", 32'(a_ifid_write), 32'd1);
    chk("rst_bubble",     32'(a_idex_bubble), 32'd0);
    chk("rst_flush",      32'(a_ifid_flush), 32'd0);
    chk("rst_busy",       32'(a_md_busy),    32'd0);
    chk("rst_overrun",    32'(a_md_overrun), 32'd0);
    chk("rst_cnt",        32'(a_stall_cnt),  32'd0);

    // Load-use, then r0 and unused-operand cases.
    do_reset();
    set_lu(); #1;
    chk("lu_pc_write",   32'(a_pc_write),    32'd0);
    chk("lu_ifid_write", 32'(a_ifid_write),  32'd0);
    chk("lu_bubble",     32'(a_idex_bubble), 32'd1);
    next_cyc();
    set_lu(); ex_rd = 5'd0; id_rs = 5'd0; #1;
    chk("lu_r0_pc_write", 32'(a_pc_write),    32'd1);
    chk("lu_r0_bubble",   32'(a_idex_bubble), 32'd0);
    chk("lu_cnt1",        32'(a_stall_cnt),   32'd1);
    next_cyc();
    set_lu(); id_usesRs = 1'b0; #1;
    chk("lu_nouse_bubble", 32'(a_idex_bubble), 32'd0);
    next_cyc();
    set_lu(); id_rs = 5'd0; id_usesRs = 1'b0; id_rt = 5'd5; id_usesRt = 1'b1; #1;
    chk("lu_rt_bubble", 32'(a_idex_bubble), 32'd1);

    // Branch on a load: EX stage then MEM stage, two stalls total.
    do_reset();
    id_branch = 1'b1; id_rt = 5'd9; id_usesRt = 1'b1;
    ex_memRead = 1'b1; ex_regWrite = 1'b1; ex_rd = 5'd9; #1;
    chk("bld_c0_bubble", 32'(a_idex_bubble), 32'd1);
    chk("bld_c0_cnt",    32'(a_stall_cnt),   32'd0);
    next_cyc();
    ex_memRead = 1'b0; ex_regWrite = 1'b0; ex_rd = 5'd0;
    mem_memRead = 1'b1; mem_rd = 5'd9; #1;
    chk("bld_c1_bubble", 32'(a_idex_bubble), 32'd1);
    chk("bld_c1_cnt",    32'(a_stall_cnt),   32'd1);
    next_cyc();
    mem_memRead = 1'b0; mem_rd = 5'd0; #1;
    chk("bld_c2_bubble", 32'(a_idex_bubble), 32'd0);
    chk("bld_c2_cnt",    32'(a_stall_cnt),   32'd2);
    next_cyc(); #1;
    chk("bld_c3_cnt",    32'(a_stall_cnt),   32'd2);

    // Taken branch on ALU result in EX: stall blocks the flush for one cycle.
    do_reset();
    id_branch = 1'b1; id_rs = 5'd2; id_usesRs = 1'b1; id_branchTaken = 1'b1;
    ex_regWrite = 1'b1; ex_rd = 5'd2; #1;
    chk("bal_c0_bubble", 32'(a_idex_bubble), 32'd1);
    chk("bal_c0_flush",  32'(a_ifid_flush),  32'd0);
    next_cyc();
    ex_regWrite = 1'b0; ex_rd = 5'd0; #1;
    chk("bal_c1_bubble", 32'(a_idex_bubble), 32'd0);
    chk("bal_c1_flush",  32'(a_ifid_flush),  32'd1);

    // Mult/div: start, HI/LO reader held, second start while busy.
    do_reset();
    ex_mdStart = 1'b1; id_mdUse = 1'b1; #1;
    chk("md_c0_busy",   32'(a_md_busy),     32'd0);
    chk("md_c0_bubble", 32'(a_idex_bubble), 32'd0);
    next_cyc();
    ex_mdStart = 1'b0; #1;
    chk("md_c1_busy",   32'(a_md_busy),     32'd1);
    chk("md_c1_bubble", 32'(a_idex_bubble), 32'd1);
    next_cyc();
    ex_mdStart = 1'b1; #1;
    chk("md_c2_busy",    32'(a_md_busy),     32'd1);
    chk("md_c2_bubble",  32'(a_idex_bubble), 32'd1);
    chk("md_c2_overrun", 32'(a_md_overrun),  32'd0);
    next_cyc();
    ex_mdStart = 1'b0; #1;
    chk("md_c3_busy",    32'(a_md_busy),     32'd1);
    chk("md_c3_bubble",  32'(a_idex_bubble), 32'd0);
    chk("md_c3_overrun", 32'(a_md_overrun),  32'd1);
    next_cyc(); #1;
    chk("md_c4_busy",    32'(a_md_busy),     32'd0);
    chk("md_c4_overrun", 32'(a_md_overrun),  32'd1);
    chk("md_c4_cnt",     32'(a_stall_cnt),   32'd2);
    next_cyc(); #1;
    chk("md_c5_busy",    32'(a_md_busy),     32'd0);

    // Asynchronous reset while busy with a non-zero stall count.
    do_reset();
    set_lu();
    repeat (7) next_cyc();
    clr_in(); ex_mdStart = 1'b1; #1;
    chk("ar_cnt7",  32'(a_stall_cnt), 32'd7);
    chk("ar_bsat",  32'(b_stall_cnt), 32'd3);
    next_cyc();
    ex_mdStart = 1'b1; #1;
    chk("ar_busy1", 32'(a_md_busy), 32'd1);
    next_cyc();
    ex_mdStart = 1'b0; #1;
    chk("ar_busy2",    32'(a_md_busy),    32'd1);
    chk("ar_overrun1", 32'(a_md_overrun), 32'd1);
    rst_n = 1'b0; #1;
    chk("ar_busy_rst",    32'(a_md_busy),    32'd0);
    chk("ar_cnt_rst",     32'(a_stall_cnt),  32'd0);
    chk("ar_overrun_rst", 32'(a_md_overrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cyc();

    // 2-bit counter saturation under a held load-use stall.
    do_reset();
    set_lu(); #1;
    chk("sat_c0", 32'(b_stall_cnt), 32'd0);
    next_cyc(); #1; chk("sat_c1", 32'(b_stall_cnt), 32'd1);
    next_cyc(); #1; chk("sat_c2", 32'(b_stall_cnt), 32'd2);
    next_cyc(); #1; chk("sat_c3", 32'(b_stall_cnt), 32'd3);
    next_cyc(); #1; chk("sat_c4", 32'(b_stall_cnt), 32'd3);
    next_cyc(); #1; chk("sat_c5", 32'(b_stall_cnt), 32'd3);
    chk("sat_wide", 32'(a_stall_cnt), 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
